// File: rtl/cr16_pkg.sv
// +----------------------------------------------------------------------------+
// | cr16_pkg : shared defaults and helpers for the CR16 multi-port regfile      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cr16_pkg;

   localparam int c_DATA_WIDTH = 16;
   localparam int c_REG_COUNT  = 16;
   localparam int c_ADDR_WIDTH = 4;

   typedef logic [c_ADDR_WIDTH-1:0] reg_idx_t;

   // Index width for a register count; a two-entry file still needs one bit.
   function automatic int f_addr_width(input int count);
      return (count <= 2) ? 1 : $clog2(count);
   endfunction

endpackage

`default_nettype wire

// File: rtl/cr16_regfile_rdport.sv
// +----------------------------------------------------------------------------+
// | cr16_regfile_rdport : one registered read port with range check and        |
// | optional write-to-read forwarding (macro CR16_REGFILE_BYPASS_EN)            |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cr16_regfile_rdport
   import cr16_pkg::*;
#(
   parameter int DATA_WIDTH = c_DATA_WIDTH,
   parameter int REG_COUNT  = c_REG_COUNT,
   parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 i_rd_en,
   input  logic [ADDR_WIDTH-1:0]                i_rd_addr,
   input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] i_regs,
   input  logic [REG_COUNT-1:0]                 i_busy,
   input  logic                                 i_wr_en,
   input  logic [ADDR_WIDTH-1:0]                i_wr_addr,
   input  logic [DATA_WIDTH-1:0]                i_wr_data,
   input  logic                                 i_lock_en,
   input  logic [ADDR_WIDTH-1:0]                i_lock_addr,
   output logic [DATA_WIDTH-1:0]                o_rd_data,
   output logic                                 o_rd_busy
);

   logic                  w_in_range;
   logic                  w_fwd;
   logic                  w_fwd_busy;
   logic [DATA_WIDTH-1:0] w_data;
   logic                  w_busy;
   logic [DATA_WIDTH-1:0] r_rd_data;
   logic                  r_rd_busy;

   assign w_in_range = (32'(i_rd_addr) < REG_COUNT);

`ifdef CR16_REGFILE_BYPASS_EN
   // A same-cycle lock still wins over the forwarded write's busy clear.
   assign w_fwd      = i_wr_en && (i_wr_addr == i_rd_addr);
   assign w_fwd_busy = i_lock_en && (i_lock_addr == i_rd_addr);
`else
   logic w_unused;
   assign w_fwd      = 1'b0;
   assign w_fwd_busy = 1'b0;
   assign w_unused   = ^{i_wr_en, i_wr_addr, i_wr_data, i_lock_en, i_lock_addr};
`endif

   always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      if (w_in_range) begin
         if (w_fwd) begin
            w_data = i_wr_data;
            w_busy = w_fwd_busy;
         end else begin
            w_data = i_regs[i_rd_addr];
            w_busy = i_busy[i_rd_addr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
         r_rd_busy <= 1'b0;
      end else if (i_rd_en) begin
         r_rd_data <= w_data;
         r_rd_busy <= w_busy;
      end
   end

   assign o_rd_data = r_rd_data;
   assign o_rd_busy = r_rd_busy;

endmodule

`default_nettype wire

// File: rtl/cr16_regfile_mp.sv
// +----------------------------------------------------------------------------+
// | cr16_regfile_mp : 1W/2R register file with per-register busy scoreboard    |
// | Optional forwarding via macro CR16_REGFILE_BYPASS_EN                        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module cr16_regfile_mp
   import cr16_pkg::*;
#(
   parameter  int DATA_WIDTH = c_DATA_WIDTH,
   parameter  int REG_COUNT  = c_REG_COUNT,
   localparam int ADDR_WIDTH = f_addr_width(REG_COUNT)
) (
   input  logic                  I_CLK,
   input  logic                  I_RESET,
   input  logic                  I_WR_EN,
   input  logic [ADDR_WIDTH-1:0] I_WR_ADDR,
   input  logic [DATA_WIDTH-1:0] I_WR_DATA,
   input  logic                  I_RD_EN_A,
   input  logic [ADDR_WIDTH-1:0] I_RD_ADDR_A,
   input  logic                  I_RD_EN_B,
   input  logic [ADDR_WIDTH-1:0] I_RD_ADDR_B,
   output logic [DATA_WIDTH-1:0] O_RD_DATA_A,
   output logic [DATA_WIDTH-1:0] O_RD_DATA_B,
   output logic                  O_RD_BUSY_A,
   output logic                  O_RD_BUSY_B,
   input  logic                  I_LOCK_EN,
   input  logic [ADDR_WIDTH-1:0] I_LOCK_ADDR,
   output logic [REG_COUNT-1:0]  O_BUSY_VEC
);

   logic [REG_COUNT-1:0][DATA_WIDTH-1:0] w_regs;
   logic [REG_COUNT-1:0]                 w_busy;

   // Decoding against each in-range index makes out-of-range writes/locks no-ops.
   for (genvar gi = 0; gi < REG_COUNT; gi++) begin : g_reg
      logic                  w_wr_hit;
      logic                  w_lock_hit;
      logic [DATA_WIDTH-1:0] r_data;
      logic                  r_bsy;

      assign w_wr_hit   = I_WR_EN   && (I_WR_ADDR   == ADDR_WIDTH'(gi));
      assign w_lock_hit = I_LOCK_EN && (I_LOCK_ADDR == ADDR_WIDTH'(gi));

      always_ff @(posedge I_CLK) begin
         if (I_RESET) begin
            r_data <= '0;
            r_bsy  <= 1'b0;
         end else begin
            if (w_wr_hit) begin
               r_data <= I_WR_DATA;
            end
            if (w_lock_hit) begin
               r_bsy <= 1'b1;
            end else if (w_wr_hit) begin
               r_bsy <= 1'b0;
            end
         end
      end

      assign w_regs[gi] = r_data;
      assign w_busy[gi] = r_bsy;
   end

   assign O_BUSY_VEC = w_busy;

   cr16_regfile_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rdport_a (
      .clk         (I_CLK),
      .rst         (I_RESET),
      .i_rd_en     (I_RD_EN_A),
      .i_rd_addr   (I_RD_ADDR_A),
      .i_regs      (w_regs),
      .i_busy      (w_busy),
      .i_wr_en     (I_WR_EN),
      .i_wr_addr   (I_WR_ADDR),
      .i_wr_data   (I_WR_DATA),
      .i_lock_en   (I_LOCK_EN),
      .i_lock_addr (I_LOCK_ADDR),
      .o_rd_data   (O_RD_DATA_A),
      .o_rd_busy   (O_RD_BUSY_A)
   );

   cr16_regfile_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .REG_COUNT  (REG_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_rdport_b (
      .clk         (I_CLK),
      .rst         (I_RESET),
      .i_rd_en     (I_RD_EN_B),
      .i_rd_addr   (I_RD_ADDR_B),
      .i_regs      (w_regs),
      .i_busy      (w_busy),
      .i_wr_en     (I_WR_EN),
      .i_wr_addr   (I_WR_ADDR),
      .i_wr_data   (I_WR_DATA),
      .i_lock_en   (I_LOCK_EN),
      .i_lock_addr (I_LOCK_ADDR),
      .o_rd_data   (O_RD_DATA_B),
      .o_rd_busy   (O_RD_BUSY_B)
   );

endmodule

`default_nettype wire

// File: tb/tb_cr16_regfile_mp.sv
// +----------------------------------------------------------------------------+
// | tb_cr16_regfile_mp : scoreboard bench for cr16_regfile_mp (12 registers)   |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_cr16_regfile_mp;

   localparam int DW = 16;
   localparam int RC = 12;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_en, rd_en_a, rd_en_b, lock_en;
   logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b, lock_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_data_a, rd_data_b;
   logic          rd_busy_a, rd_busy_b;
   logic [RC-1:0] busy_vec;

   always #5 clk = ~clk;

   cr16_regfile_mp #(.DATA_WIDTH(DW), .REG_COUNT(RC)) u_dut (
      .I_CLK       (clk),
      .I_RESET     (rst),
      .I_WR_EN     (wr_en),
      .I_WR_ADDR   (wr_addr),
      .I_WR_DATA   (wr_data),
      .I_RD_EN_A   (rd_en_a),
      .I_RD_ADDR_A (rd_addr_a),
      .I_RD_EN_B   (rd_en_b),
      .I_RD_ADDR_B (rd_addr_b),
      .O_RD_DATA_A (rd_data_a),
      .O_RD_DATA_B (rd_data_b),
      .O_RD_BUSY_A (rd_busy_a),
      .O_RD_BUSY_B (rd_busy_b),
      .I_LOCK_EN   (lock_en),
      .I_LOCK_ADDR (lock_addr),
      .O_BUSY_VEC  (busy_vec)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          busy;
   } rd_exp_t;

   rd_exp_t       qa[$];
   rd_exp_t       qb[$];
   logic [RC-1:0] qv[$];

   int            checks   = 0;
   int            failures = 0;
   bit            mon_go   = 1'b0;

   // Reference model: plain arrays indexed by register number.
   logic [DW-1:0] m_reg  [RC];
   bit            m_busy [RC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic rd_exp_t m_read(input int addr);
      rd_exp_t r;
      if (addr >= RC) begin
         r.data = '0;
         r.busy = 1'b0;
         return r;
      end
`ifdef CR16_REGFILE_BYPASS_EN
      if (wr_en && int'(wr_addr) == addr) begin
         r.data = wr_data;
         r.busy = lock_en && (int'(lock_addr) == addr);
         return r;
      end
`endif
      r.data = m_reg[addr];
      r.busy = m_busy[addr];
      return r;
   endfunction

   task automatic idle_inputs();
      rst = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0; lock_en = 1'b0;
      wr_addr = '0; rd_addr_a = '0; rd_addr_b = '0; lock_addr = '0; wr_data = '0;
   endtask

   // Apply the currently driven inputs for one clock, queueing what the DUT must show.
   task automatic tick();
      logic [RC-1:0] v;
      if (rst) begin
         for (int i = 0; i < RC; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 1'b0;
         end
      end else begin
         if (rd_en_a) qa.push_back(m_read(int'(rd_addr_a)));
         if (rd_en_b) qb.push_back(m_read(int'(rd_addr_b)));
         if (wr_en && int'(wr_addr) < RC) begin
            m_reg[int'(wr_addr)]  = wr_data;
            m_busy[int'(wr_addr)] = 1'b0;
         end
         if (lock_en && int'(lock_addr) < RC) m_busy[int'(lock_addr)] = 1'b1;
      end
      for (int i = 0; i < RC; i++) v[i] = m_busy[i];
      qv.push_back(v);
      @(posedge clk);
      #1;
      idle_inputs();
   endtask

   // Monitor: pops an expectation for each accepted read; otherwise outputs must hold.
   initial begin : monitor
      rd_exp_t       ha, hb;
      logic [RC-1:0] ev;
      bit            sa, sb, sr;
      ha.data = '0; ha.busy = 1'b0;
      hb.data = '0; hb.busy = 1'b0;
      wait (mon_go);
      forever begin
         @(posedge clk);
         sr = rst;
         sa = rd_en_a && !rst;
         sb = rd_en_b && !rst;
         @(negedge clk);
         if (sr) begin
            ha.data = '0; ha.busy = 1'b0;
            hb.data = '0; hb.busy = 1'b0;
         end else begin
            if (sa) begin
               if (qa.size() == 0) chk("queue_a_underflow", 32'd1, 32'd0);
               else ha = qa.pop_front();
            end
            if (sb) begin
               if (qb.size() == 0) chk("queue_b_underflow", 32'd1, 32'd0);
               else hb = qb.pop_front();
            end
         end
         chk("rd_data_a", 32'(rd_data_a), 32'(ha.data));
         chk("rd_busy_a", 32'(rd_busy_a), 32'(ha.busy));
         chk("rd_data_b", 32'(rd_data_b), 32'(hb.data));
         chk("rd_busy_b", 32'(rd_busy_b), 32'(hb.busy));
         if (qv.size() == 0) begin
            chk("queue_v_underflow", 32'd1, 32'd0);
         end else begin
            ev = qv.pop_front();
            chk("busy_vec", 32'(busy_vec), 32'(ev));
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench timeout");
   end

   initial begin : driver
      idle_inputs();
      for (int i = 0; i < RC; i++) begin
         m_reg[i]  = '0;
         m_busy[i] = 1'b0;
      end
      mon_go = 1'b1;

      rst = 1'b1; tick();
      rst = 1'b1; tick();

      // Reset clears contents written before it.
      wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF; tick();
      rst = 1'b1; tick();
      rd_en_a = 1'b1; rd_addr_a = 4'd3; tick();
      tick();

      // Sweep every register with j, read back on both ports.
      for (int j = 0; j < 65536; j += 1024) begin
         for (int r = 0; r < RC; r++) begin
            wr_en = 1'b1; wr_addr = AW'(r); wr_data = DW'(j); tick();
            rd_en_a = 1'b1; rd_addr_a = AW'(r);
            rd_en_b = 1'b1; rd_addr_b = AW'(r); tick();
         end
      end

      // Scoreboard lock / release / simultaneous lock and write.
      lock_en = 1'b1; lock_addr = 4'd5; tick();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0042; tick();
      lock_en = 1'b1; lock_addr = 4'd5;
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h0043; tick();
      rd_en_a = 1'b1; rd_addr_a = 4'd5; rd_en_b = 1'b1; rd_addr_b = 4'd5; tick();

      // Same-cycle write and read of r7.
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h1111; tick();
      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h2222;
      rd_en_a = 1'b1; rd_addr_a = 4'd7; tick();
      rd_en_a = 1'b1; rd_addr_a = 4'd7; tick();

      // Output holds while read enable is low.
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'hA5A5; tick();
      rd_en_a = 1'b1; rd_addr_a = 4'd2; tick();
      wr_en = 1'b1; wr_addr = 4'd2; wr_data = 16'h0000; tick();
      tick();
      tick();

      // Out-of-range write/lock are ignored; out-of-range read returns zero.
      wr_en = 1'b1; wr_addr = 4'd13; wr_data = 16'hDEAD;
      lock_en = 1'b1; lock_addr = 4'd13; tick();
      for (int r = 0; r < 16; r++) begin
         rd_en_a = 1'b1; rd_addr_a = AW'(r);
         rd_en_b = 1'b1; rd_addr_b = AW'(15 - r); tick();
      end

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 2000; n++) begin
         rst       = ($urandom_range(0, 63) == 0);
         wr_en     = 1'($urandom_range(0, 1));
         wr_addr   = AW'($urandom_range(0, 15));
         wr_data   = DW'($urandom);
         lock_en   = ($urandom_range(0, 3) == 0);
         lock_addr = ($urandom_range(0, 1) == 0) ? wr_addr : AW'($urandom_range(0, 15));
         rd_en_a   = 1'($urandom_range(0, 1));
         rd_addr_a = ($urandom_range(0, 2) == 0) ? wr_addr : AW'($urandom_range(0, 15));
         rd_en_b   = 1'($urandom_range(0, 1));
         rd_addr_b = ($urandom_range(0, 2) == 0) ? rd_addr_a : AW'($urandom_range(0, 15));
         tick();
      end

      tick();
      @(negedge clk);
      #1;
      chk("queues_drained", 32'(qa.size() + qb.size() + qv.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
